// File: rtl/timeout_pkg.sv
// Shared definitions for the timeout scheduler: channel state encoding and default sizes.
package timeout_pkg;

    localparam int unsigned CH_DEF = 4;
    localparam int unsigned TW_DEF = 8;
    localparam int unsigned PW_DEF = 20;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/timeout_sched_prescaler.sv
// Free-running prescaler: WIDTH-bit up-counter with synchronous clear and count enable.
// co is the carry out, high while enabled and the count sits at its all-ones value.
module timeout_sched_prescaler #(
    parameter int unsigned WIDTH = 20
) (
    input  logic clk,
    input  logic clr,
    input  logic ce,
    output logic co
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear dominates, otherwise advance when enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (ce) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign co = ce & (&count_q);

endmodule

// File: rtl/timeout_sched.sv
// Multi-channel timeout scheduler: CH independent down-counters in prescaler ticks,
// sharing one prescaler whose phase restarts when the first channel leaves all-idle.
module timeout_sched
    import timeout_pkg::*;
#(
    parameter int unsigned CH = CH_DEF,
    parameter int unsigned TW = TW_DEF,
    parameter int unsigned PW = PW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic [CH-1:0] start,
    input  logic [CH-1:0] stop,
    input  logic [TW-1:0] tval,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] expire,
    output logic          tick
);

    logic any_run;
    logic presc_clr;

    // busy is already registered, so the prescaler holds cleared through the cycle
    // in which the first channel starts and begins counting on the following edge.
    assign any_run   = |busy;
    assign presc_clr = ~any_run | ~clr;

    timeout_sched_prescaler #(
        .WIDTH (PW)
    ) u_presc (
        .clk (clk),
        .clr (presc_clr),
        .ce  (en),
        .co  (tick)
    );

    for (genvar i = 0; i < int'(CH); i++) begin : g_ch
        ch_state_t     state_q;
        ch_state_t     state_d;
        logic [TW-1:0] cnt_q;
        logic [TW-1:0] cnt_d;
        logic          exp_q;
        logic          exp_d;

        // Channel next-state: start wins over stop, stop wins over a terminal tick.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            exp_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start[i]) begin
                        if (tval != '0) begin
                            state_d = ST_RUN;
                            cnt_d   = tval;
                        end else begin
                            exp_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (start[i]) begin
                        if (tval != '0) begin
                            cnt_d = tval;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            exp_d   = 1'b1;
                        end
                    end else if (stop[i]) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == TW'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            exp_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q - TW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Channel state, counter and expire pulse registers with synchronous reset.
        always_ff @(posedge clk) begin
            if (!clr) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                exp_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                exp_q   <= exp_d;
            end
        end

        assign busy[i]   = (state_q == ST_RUN);
        assign expire[i] = exp_q;
    end

endmodule

// File: tb/tb_timeout_sched.sv
// Scoreboard bench for timeout_sched with PW=2 (tick every 4 enabled cycles).
module tb_timeout_sched;

    localparam int unsigned CH  = 4;
    localparam int unsigned TW  = 8;
    localparam int unsigned PW  = 2;
    localparam int          PER = 1 << PW;

    logic          clk = 1'b0;
    logic          clr;
    logic          en;
    logic [CH-1:0] start;
    logic [CH-1:0] stop;
    logic [TW-1:0] tval;
    logic [CH-1:0] busy;
    logic [CH-1:0] expire;
    logic          tick;

    timeout_sched #(
        .CH (CH),
        .TW (TW),
        .PW (PW)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .start  (start),
        .stop   (stop),
        .tval   (tval),
        .busy   (busy),
        .expire (expire),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] busy;
        logic [CH-1:0] expire;
        logic          tick;
    } exp_t;

    exp_t sb[$];

    // Reference model: remaining ticks per channel (0 = idle), pending expire flags,
    // and the prescaler phase in enabled cycles since the last restart.
    int rem[CH];
    bit xp[CH];
    int phase = 0;

    int vectors     = 0;
    int miscompares = 0;

    initial begin
        for (int c = 0; c < int'(CH); c++) begin
            rem[c] = 0;
            xp[c]  = 1'b0;
        end
    end

    function automatic exp_t predict();
        exp_t e;
        for (int c = 0; c < int'(CH); c++) begin
            e.busy[c]   = (rem[c] > 0);
            e.expire[c] = xp[c];
        end
        e.tick = (en === 1'b1) && (phase == PER - 1);
        return e;
    endfunction

    // Model advance at each rising edge using the inputs held across it.
    always @(posedge clk) begin
        int nrem[CH];
        bit nxp[CH];
        int nph;
        bit tk;
        bit anyrun;
        anyrun = 1'b0;
        for (int c = 0; c < int'(CH); c++) if (rem[c] > 0) anyrun = 1'b1;
        tk = (en === 1'b1) && (phase == PER - 1);
        if (clr !== 1'b1) begin
            for (int c = 0; c < int'(CH); c++) begin
                nrem[c] = 0;
                nxp[c]  = 1'b0;
            end
            nph = 0;
        end else begin
            nph = !anyrun ? 0 : ((en === 1'b1) ? (phase + 1) % PER : phase);
            for (int c = 0; c < int'(CH); c++) begin
                nrem[c] = rem[c];
                nxp[c]  = 1'b0;
                if (start[c]) begin
                    nrem[c] = int'(tval);
                    if (tval == 0) nxp[c] = 1'b1;
                end else if (rem[c] > 0 && stop[c]) begin
                    nrem[c] = 0;
                end else if (rem[c] > 0 && tk) begin
                    nrem[c] = rem[c] - 1;
                    if (nrem[c] == 0) nxp[c] = 1'b1;
                end
            end
        end
        rem   <= nrem;
        xp    <= nxp;
        phase <= nph;
    end

    // Drive one cycle of inputs at the falling edge and queue the expected outputs.
    task automatic cyc(input logic c, input logic e, input logic [CH-1:0] s,
                       input logic [CH-1:0] p, input logic [TW-1:0] v, input bit chk);
        @(negedge clk);
        clr   = c;
        en    = e;
        start = s;
        stop  = p;
        tval  = v;
        if (chk) sb.push_back(predict());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, '0, '0, '0, 1'b1);
    endtask

    // Monitor: pops one expectation per cycle and compares the visible outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL busy t=%0t got %b want %b", $time, busy, e.busy);
                end
                vectors++;
                if (expire !== e.expire) begin
                    miscompares++;
                    $display("FAIL expire t=%0t got %b want %b", $time, expire, e.expire);
                end
                vectors++;
                if (tick !== e.tick) begin
                    miscompares++;
                    $display("FAIL tick t=%0t got %b want %b", $time, tick, e.tick);
                end
            end
        end
    end

    initial begin
        logic [CH-1:0] rs;
        logic [CH-1:0] rp;
        clr   = 1'b0;
        en    = 1'b0;
        start = '0;
        stop  = '0;
        tval  = '0;
        cyc(1'b0, 1'b1, '0, '0, '0, 1'b0);
        cyc(1'b0, 1'b1, '0, '0, '0, 1'b1);
        idle(2);

        // Single channel, three ticks.
        cyc(1'b1, 1'b1, 4'b0001, '0, 8'd3, 1'b1);
        idle(16);

        // Cancel mid-run.
        cyc(1'b1, 1'b1, 4'b0010, '0, 8'd5, 1'b1);
        idle(5);
        cyc(1'b1, 1'b1, '0, 4'b0010, '0, 1'b1);
        idle(25);

        // Restart while running keeps the phase.
        cyc(1'b1, 1'b1, 4'b0100, '0, 8'd2, 1'b1);
        idle(5);
        cyc(1'b1, 1'b1, 4'b0100, '0, 8'd2, 1'b1);
        idle(15);

        // Simultaneous expiry, then zero timeout from idle and from run.
        cyc(1'b1, 1'b1, 4'b1001, '0, 8'd1, 1'b1);
        idle(8);
        cyc(1'b1, 1'b1, 4'b0010, '0, 8'd0, 1'b1);
        idle(3);
        cyc(1'b1, 1'b1, 4'b0001, '0, 8'd3, 1'b1);
        idle(2);
        cyc(1'b1, 1'b1, 4'b0001, '0, 8'd0, 1'b1);
        idle(10);

        // Start beats stop; stop while idle does nothing.
        cyc(1'b1, 1'b1, 4'b0001, 4'b0001, 8'd2, 1'b1);
        idle(12);
        cyc(1'b1, 1'b1, '0, 4'b1111, '0, 1'b1);
        idle(2);

        // Stop wins over the terminal tick: ch1 reaches its last tick at the stop edge.
        cyc(1'b1, 1'b1, 4'b0010, '0, 8'd1, 1'b1);
        idle(3);
        cyc(1'b1, 1'b1, '0, 4'b0010, '0, 1'b1);
        idle(6);

        // Enable dropped for 10 cycles mid-run.
        cyc(1'b1, 1'b1, 4'b0001, '0, 8'd2, 1'b1);
        idle(2);
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, '0, '0, '0, 1'b1);
        idle(15);

        // Reset mid-run discards everything.
        cyc(1'b1, 1'b1, 4'b1111, '0, 8'd3, 1'b1);
        idle(5);
        cyc(1'b0, 1'b1, '0, '0, '0, 1'b1);
        idle(20);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < int'(CH); c++) begin
                rs[c] = ($urandom_range(0, 11) == 0);
                rp[c] = ($urandom_range(0, 15) == 0);
            end
            cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0), rs, rp,
                TW'($urandom_range(0, 5)), 1'b1);
        end
        idle(30);

        repeat (3) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain left=%0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
